// File: rtl/ram_share_fifo_ctrl.sv
// Two write requesters share one dual-port RAM used as a FIFO, drained through a registered output stage.
// Define FIXED_PRIORITY_ARB_EN to make req0 always win ties; otherwise ties are resolved round-robin.
module ram_share_fifo_ctrl #(
  parameter int addr_width = 4,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [data_width-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [data_width-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  input  logic                  out_ready,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr_wr,
  output logic [addr_width-1:0] ram_addr_rd,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout,
  output logic [addr_width:0]   level,
  output logic                  full
);

  localparam logic [addr_width:0] full_level = {1'b1, {addr_width{1'b0}}};

  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   level_q, level_d;
  logic                  out_valid_q, out_valid_d;
  logic [data_width-1:0] out_data_q, out_data_d;
  logic                  grant0, grant1, wr_acc, load;

`ifdef FIXED_PRIORITY_ARB_EN
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`else
  // last1_q set means req1 took the most recent accepted write, so req0 wins the next tie.
  logic last1_q, last1_d;

  always_comb begin
    grant1  = req1_valid & (~req0_valid | ~last1_q);
    grant0  = req0_valid & ~grant1;
    last1_d = wr_acc ? grant1 : last1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) last1_q <= 1'b1;
    else       last1_q <= last1_d;
  end
`endif

  // Handshake: a requester's word is taken at the edge ending a cycle with valid & ready;
  // ready is the grant gated by pre-edge full and reset, never by out_ready.
  always_comb begin
    full       = (level_q == full_level);
    req0_ready = grant0 & ~full & ~reset;
    req1_ready = grant1 & ~full & ~reset;
    wr_acc     = req0_ready | req1_ready;
    load       = (level_q != '0) & (~out_valid_q | out_ready);
  end

  always_comb begin
    wr_ptr_d    = wr_acc ? wr_ptr_q + addr_width'(1) : wr_ptr_q;
    rd_ptr_d    = load ? rd_ptr_q + addr_width'(1) : rd_ptr_q;
    level_d     = level_q;
    if (wr_acc && !load)      level_d = level_q + (addr_width+1)'(1);
    else if (!wr_acc && load) level_d = level_q - (addr_width+1)'(1);
    out_data_d  = load ? ram_dout : out_data_q;
    out_valid_d = out_valid_q;
    if (load)           out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    ram_we      = wr_acc;
    ram_din     = grant1 ? req1_data : req0_data;
    ram_addr_wr = wr_ptr_q;
    ram_addr_rd = rd_ptr_q;
    out_valid   = out_valid_q;
    out_data    = out_data_q;
    level       = level_q;
  end

endmodule

// File: tb/tb_ram_share_fifo_ctrl.sv
// Directed bench for ram_share_fifo_ctrl with a behavioural dual-port RAM and an expected-output queue.
module tb_ram_share_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       ram_we;
  logic [3:0] ram_addr_wr, ram_addr_rd;
  logic [7:0] ram_din, ram_dout;
  logic [4:0] level;
  logic       full;

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] i0, i1, n;

  always #5 clk = ~clk;

  ram_share_fifo_ctrl #(.addr_width(4), .data_width(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ram_we(ram_we), .ram_addr_wr(ram_addr_wr), .ram_addr_rd(ram_addr_rd),
    .ram_din(ram_din), .ram_dout(ram_dout), .level(level), .full(full)
  );

  always @(posedge clk) if (ram_we) mem[ram_addr_wr] <= ram_din;
  assign ram_dout = mem[ram_addr_rd];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_out(input string tag);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk({tag, "_extra"}, exp_q.size(), 1);
      else chk(tag, out_data, exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset behaviour, single write latency
    reset = 1'b1; req0_valid = 1'b1; req0_data = 8'h11; req1_valid = 1'b0; req1_data = 8'h00;
    out_ready = 1'b0;
    tick(); tick();
    settle();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_full", full, 0);
    reset = 1'b0; out_ready = 1'b1;
    settle();
    chk("c0_ready0", req0_ready, 1);
    chk("c0_we", ram_we, 1);
    chk("c0_din", ram_din, 8'h11);
    chk("c0_addr_wr", ram_addr_wr, 0);
    tick();
    req0_valid = 1'b0;
    settle();
    chk("c1_level", level, 1);
    chk("c1_no_bypass", out_valid, 0);
    chk("c1_we", ram_we, 0);
    tick(); settle();
    chk("c2_out_valid", out_valid, 1);
    chk("c2_out_data", out_data, 8'h11);
    chk("c2_level", level, 0);
    chk("c2_addr_rd", ram_addr_rd, 1);
    tick(); settle();
    chk("c3_out_valid", out_valid, 0);

    // Tie arbitration over six cycles; requesters hold data until accepted
    do_reset();
    out_ready = 1'b1;
    i0 = 8'h00; i1 = 8'h00;
`ifdef FIXED_PRIORITY_ARB_EN
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
`else
    exp_q = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
`endif
    for (int k = 0; k < 6; k++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = 8'hA0 + i0; req1_data = 8'hB0 + i1;
      settle();
`ifdef FIXED_PRIORITY_ARB_EN
      chk("arb_ready0", req0_ready, 1);
      chk("arb_ready1", req1_ready, 0);
`else
      chk("arb_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
      chk("arb_ready1", req1_ready, (k % 2 == 1) ? 1 : 0);
`endif
      if (req0_ready) i0 = i0 + 8'd1;
      if (req1_ready) i1 = i1 + 8'd1;
      check_out("arb_out");
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
      check_out("arb_out");
      tick();
    end
    chk("arb_all_out", exp_q.size(), 0);

    // Fill with the output stalled: 16 in RAM plus one in the output register
    do_reset();
    n = 8'h00;
    for (int k = 0; k < 20; k++) begin
      req0_valid = 1'b1; req0_data = 8'h40 + n;
      settle();
      if (req0_ready) n = n + 8'd1;
      tick();
    end
    chk("fill_accepted", n, 17);
    settle();
    chk("fill_full", full, 1);
    chk("fill_level", level, 16);
    chk("fill_ready0", req0_ready, 0);
    chk("fill_out_valid", out_valid, 1);
    chk("fill_out_hold", out_data, 8'h40);
    chk("fill_addr_wr", ram_addr_wr, 1);
    chk("fill_addr_rd", ram_addr_rd, 1);

    // One-cycle drain at full: the write stays blocked that cycle, then goes through
    req0_data = 8'h51; out_ready = 1'b1;
    settle();
    chk("pulse_ready0", req0_ready, 0);
    chk("pulse_we", ram_we, 0);
    tick();
    out_ready = 1'b0;
    settle();
    chk("after_pulse_level", level, 15);
    chk("after_pulse_full", full, 0);
    chk("after_pulse_ready0", req0_ready, 1);
    chk("after_pulse_addr_wr", ram_addr_wr, 1);
    chk("after_pulse_din", ram_din, 8'h51);
    chk("after_pulse_out_data", out_data, 8'h41);
    tick();
    req0_valid = 1'b0;
    settle();
    chk("refill_level", level, 16);
    chk("refill_full", full, 1);
    chk("refill_addr_wr", ram_addr_wr, 2);

    // Drain everything across the pointer wrap
    for (int v = 8'h41; v <= 8'h51; v++) exp_q.push_back(8'(v));
    out_ready = 1'b1;
    for (int k = 0; k < 22; k++) begin
      settle();
      check_out("drain_out");
      tick();
    end
    chk("drain_all_out", exp_q.size(), 0);
    settle();
    chk("drain_level", level, 0);

    // Reset in the middle of operation
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req0_valid = 1'b1; req0_data = 8'h60 + 8'(k);
      tick();
    end
    req0_valid = 1'b0;
    settle();
    chk("mid_level", level, 5);
    chk("mid_out_valid", out_valid, 1);
    chk("mid_out_data", out_data, 8'h60);
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 8'h70; req1_data = 8'h80;
    settle();
    chk("mid_rst_ready0", req0_ready, 0);
    chk("mid_rst_ready1", req1_ready, 0);
    chk("mid_rst_we", ram_we, 0);
    tick();
    reset = 1'b0;
    settle();
    chk("post_rst_level", level, 0);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_out_data", out_data, 8'h00);
    chk("post_rst_addr_rd", ram_addr_rd, 0);
    chk("post_rst_addr_wr", ram_addr_wr, 0);
    chk("post_rst_tie_ready0", req0_ready, 1);
    chk("post_rst_tie_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
